// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-16 frame sequencer: FSM state encoding and
// default datapath widths.
package crc_pkg;

    localparam int DW_DEF      = 32;
    localparam int CW_DEF      = 16;
    localparam int LEN_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 80;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WAIT_WORD = 3'd2,
        LOAD      = 3'd3,
        SHIFT     = 3'd4,
        CAPTURE   = 3'd5
    } state_t;

endpackage

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the 32-bit PISO / CRC-16 block: clears the CRC block,
// feeds each word through it and captures the final LFSR value.
module crc_frame_ctrl
    import crc_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int CW      = CW_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             word_valid,
    input  logic [DW-1:0]    word_data,
    output logic             word_ready,
    output logic             crc_rstn_o,
    output logic             crc_load,
    output logic             crc_enable,
    output logic [DW-1:0]    crc_data,
    input  logic             crc_done_tick,
    input  logic [CW-1:0]    crc_lfsr,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    crc_result,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [TW-1:0]    tmo_cnt;

    assign word_ready = (state == WAIT_WORD);
    // The CRC block is held in reset for the single CLEAR cycle and whenever we are reset.
    assign crc_rstn_o = rstn && (state != CLEAR);

    // Strobes and status are registered from the next state, so they line up with it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            remaining  <= '0;
            tmo_cnt    <= '0;
            crc_data   <= '0;
            crc_result <= '0;
            crc_load   <= 1'b0;
            crc_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                crc_load   <= 1'b0;
                crc_enable <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (frame_len != '0) begin
                                remaining <= frame_len;
                                state     <= CLEAR;
                                busy      <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    CLEAR: state <= WAIT_WORD;
                    WAIT_WORD: begin
                        if (word_valid) begin
                            crc_data   <= word_data;
                            state      <= LOAD;
                            crc_load   <= 1'b1;
                            crc_enable <= 1'b1;
                        end
                    end
                    LOAD: begin
                        crc_load <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= SHIFT;
                    end
                    SHIFT: begin
                        if (crc_done_tick) begin
                            remaining  <= remaining - LEN_W'(1);
                            crc_enable <= 1'b0;
                            if (remaining == LEN_W'(1)) begin
                                // LFSR is already final here and stays frozen through CAPTURE.
                                state      <= CAPTURE;
                                crc_result <= crc_lfsr;
                                done       <= 1'b1;
                            end else begin
                                state <= WAIT_WORD;
                            end
                        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            err        <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            crc_enable <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    CAPTURE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        crc_load   <= 1'b0;
                        crc_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: drives frames into the sequencer, models the PISO/CRC-16
// block behaviourally and compares crc_result with a polynomial-division reference.
module tb_crc_frame_ctrl;
    import crc_pkg::*;

    localparam int DW      = 32;
    localparam int CW      = 16;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 80;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             abort;
    logic             word_valid;
    logic [DW-1:0]    word_data;
    logic             word_ready;
    logic             crc_rstn_o;
    logic             crc_load;
    logic             crc_enable;
    logic [DW-1:0]    crc_data;
    logic             crc_done_tick;
    logic [CW-1:0]    crc_lfsr;
    logic             busy;
    logic             done;
    logic [CW-1:0]    crc_result;
    logic             err;

    always #5 clk = ~clk;

    crc_frame_ctrl #(.DW(DW), .CW(CW), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .frame_len(frame_len), .abort(abort),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .crc_rstn_o(crc_rstn_o), .crc_load(crc_load), .crc_enable(crc_enable),
        .crc_data(crc_data), .crc_done_tick(crc_done_tick), .crc_lfsr(crc_lfsr),
        .busy(busy), .done(done), .crc_result(crc_result), .err(err)
    );

    // Behavioural PISO + CRC-16 (x^16+x^12+x^5+1, zero init, MSB first) block.
    logic [DW-1:0] piso;
    int            bcnt;
    logic          tick_raw;
    logic          kill_tick;
    assign crc_done_tick = tick_raw && !kill_tick;

    always_ff @(posedge clk) begin
        if (!crc_rstn_o) begin
            piso     <= '0;
            bcnt     <= 0;
            crc_lfsr <= '0;
            tick_raw <= 1'b0;
        end else if (crc_load) begin
            piso     <= crc_data;
            bcnt     <= DW;
            tick_raw <= 1'b0;
        end else if (crc_enable && bcnt != 0) begin
            crc_lfsr <= {crc_lfsr[CW-2:0], 1'b0} ^ ((crc_lfsr[CW-1] ^ piso[DW-1]) ? 16'h1021 : 16'h0000);
            piso     <= {piso[DW-2:0], 1'b0};
            bcnt     <= bcnt - 1;
            tick_raw <= (bcnt == 1);
        end else begin
            tick_raw <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of M(x)*x^16 divided by G(x) = 0x11021, message taken MSB first.
    function automatic logic [CW-1:0] fcs_ref(input logic [DW-1:0] w[$]);
        logic [CW:0] rem;
        int          nmsg;
        logic        b;
        rem  = '0;
        nmsg = w.size() * DW;
        for (int i = 0; i < nmsg + CW; i++) begin
            b   = (i < nmsg) ? w[i / DW][DW - 1 - (i % DW)] : 1'b0;
            rem = {rem[CW-1:0], b};
            if (rem[CW]) rem = rem ^ 17'h11021;
        end
        return rem[CW-1:0];
    endfunction

    // Event monitor sampled on the falling edge.
    int cyc = 0, tick_cyc = 0, done_cyc = 0, clear_cyc = 0;
    int n_done = 0, n_err = 0, n_load = 0, n_clear = 0;
    int shift_run = 0, shift_at_err = 0, busy_low = 0;
    bit track = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (crc_done_tick) tick_cyc = cyc;
        if (done) begin
            done_cyc = cyc;
            n_done++;
        end
        if (err) begin
            n_err++;
            shift_at_err = shift_run;
        end
        if (crc_load) begin
            n_load++;
            shift_run = 0;
        end else if (crc_enable) begin
            shift_run++;
        end
        if (rstn && !crc_rstn_o) begin
            n_clear++;
            clear_cyc = cyc;
        end
        if (track && !busy) busy_low++;
    end

    logic [DW-1:0] wq[$];

    task automatic pulse_start(input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        start = 1'b1; frame_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w, input int gap);
        int guard;
        guard = 0;
        word_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        word_valid = 1'b1; word_data = w;
        do begin
            @(negedge clk);
            guard++;
        end while (!word_ready && guard < 500);
        if (!word_ready) check_eq("word_ready_wait", 32'(word_ready), 32'd1);
        @(posedge clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic wait_event(input int d0, input int e0);
        int guard;
        guard = 0;
        while (n_done == d0 && n_err == e0 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) check_eq("event_wait", 32'(guard), 32'd0);
    endtask

    task automatic run_frame(input int gap, input bit poke);
        int            d0, l0;
        logic [CW-1:0] exp;
        d0  = n_done;
        l0  = n_load;
        exp = fcs_ref(wq);
        pulse_start(LEN_W'(wq.size()));
        track = 1'b1;
        foreach (wq[i]) begin
            push_word(wq[i], gap);
            if (poke && i == 0) begin
                start = 1'b1; frame_len = 8'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_event(d0, n_err);
        track = 1'b0;
        check_eq("loads", 32'(n_load - l0), 32'(wq.size()));
        check_eq("done_cnt", 32'(n_done - d0), 32'd1);
        check_eq("crc_result", 32'(crc_result), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
        check_eq({pfx, "_done"}, 32'(done), 32'd0);
        check_eq({pfx, "_err"}, 32'(err), 32'd0);
        check_eq({pfx, "_ready"}, 32'(word_ready), 32'd0);
        check_eq({pfx, "_load"}, 32'(crc_load), 32'd0);
        check_eq({pfx, "_enable"}, 32'(crc_enable), 32'd0);
        check_eq({pfx, "_crc_rstn"}, 32'(crc_rstn_o), 32'd0);
        check_eq({pfx, "_crc_data"}, crc_data, 32'd0);
        check_eq({pfx, "_result"}, 32'(crc_result), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed time-out expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            c0, d0, e0;
        logic [CW-1:0] r0;
        rstn = 1'b0; start = 1'b0; frame_len = '0; abort = 1'b0;
        word_valid = 1'b0; word_data = '0; kill_tick = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single word, valid held high
        wq = '{32'hDEADBEEF};
        c0 = n_clear;
        run_frame(0, 1'b0);
        check_eq("clear_pulses", 32'(n_clear - c0), 32'd1);
        check_eq("done_after_tick", 32'(done_cyc - tick_cyc), 32'd1);
        check_eq("latency", 32'(done_cyc - clear_cyc + 1), 32'(1 + (2 + DW + 1) + 1));
        @(negedge clk);
        check_eq("done_width", 32'(done), 32'd0);

        // Three words with 5-cycle gaps
        wq = '{32'h00000001, 32'h12345678, 32'hFFFFFFFF};
        busy_low = 0;
        run_frame(5, 1'b0);
        check_eq("busy_hold", 32'(busy_low), 32'd0);

        // Zero-length request
        r0 = crc_result;
        pulse_start('0);
        @(negedge clk);
        check_eq("zlen_err", 32'(err), 32'd1);
        check_eq("zlen_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("zlen_err_width", 32'(err), 32'd0);
        check_eq("zlen_result", 32'(crc_result), 32'(r0));

        // Timeout: the done tick never arrives
        kill_tick = 1'b1;
        r0 = crc_result; d0 = n_done; e0 = n_err;
        pulse_start(8'd1);
        push_word($urandom(), 0);
        wait_event(d0, e0);
        check_eq("tmo_err", 32'(n_err - e0), 32'd1);
        check_eq("tmo_cycles", 32'(shift_at_err), 32'(TIMEOUT));
        check_eq("tmo_done", 32'(n_done - d0), 32'd0);
        @(negedge clk);
        check_eq("tmo_busy", 32'(busy), 32'd0);
        check_eq("tmo_result", 32'(crc_result), 32'(r0));
        kill_tick = 1'b0;

        // Abort during the second word of three, then a fresh zero word
        d0 = n_done; e0 = n_err;
        pulse_start(8'd3);
        push_word($urandom(), 0);
        push_word($urandom(), 0);
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_enable", 32'(crc_enable), 32'd0);
        check_eq("abort_ready", 32'(word_ready), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_no_done", 32'(n_done - d0), 32'd0);
        check_eq("abort_no_err", 32'(n_err - e0), 32'd0);
        wq = '{32'h00000000};
        run_frame(0, 1'b0);

        // Start while busy must not disturb the running two-word frame
        wq = '{$urandom(), $urandom()};
        run_frame(0, 1'b1);

        // Reset pulled mid-shift
        pulse_start(8'd2);
        push_word($urandom(), 0);
        repeat (8) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("midrst_idle_busy", 32'(busy), 32'd0);
        check_eq("midrst_crc_rstn", 32'(crc_rstn_o), 32'd1);

        // Random frames
        for (int f = 0; f < 5; f++) begin
            int len;
            len = int'($urandom_range(1, 4));
            wq.delete();
            for (int k = 0; k < len; k++) wq.push_back($urandom());
            run_frame(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
Sequencer for the 32-bit PISO to CRC-16 (FCS) datapath. It accepts a frame as a word count plus a valid/ready stream of 32-bit words, then clears the CRC block. It then loads and shifts each word in turn, waits for each serial-done tick, and captures the final 16-bit LFSR value as the frame CRC. The block sits between the SPI/register front end and the CRC block, and owns all of the CRC block's control inputs.

Parameters:
DW, 32, word width; must match the CRC block's data input width.
CW, 16, CRC/LFSR width.
LEN_W, 8, width of the frame word count (1 to 2^LEN_W-1 words per frame).
TIMEOUT, 80, maximum cycles in SHIFT without a done tick before abort (must be at least DW+2).

Ports:
clk  in  1  system clock
rstn  in  1  synchronous, active-low reset
start  in  1  frame request pulse, sampled in IDLE only
frame_len  in  LEN_W  number of words in the frame, latched on start
abort  in  1  synchronous abort, valid in any state
word_valid  in  1  word_data is valid
word_data  in  DW  frame word
word_ready  out  1  controller accepts word_data this cycle
crc_rstn_o  out  1  reset to the CRC block (active-low)
crc_load  out  1  PISO parallel load strobe
crc_enable  out  1  PISO shift enable
crc_data  out  DW  registered word driven to the CRC block
crc_done_tick  in  1  PISO serial-done tick
crc_lfsr  in  CW  CRC block LFSR value
busy  out  1  a frame is in progress
done  out  1  one-cycle pulse when crc_result is updated
crc_result  out  CW  CRC of the last completed frame
err  out  1  one-cycle pulse: zero length or timeout

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state goes to IDLE.
  - crc_data, crc_result and the remaining-word and timeout counters go to 0.
  - busy, done, err, word_ready, crc_load and crc_enable go to 0.
  - crc_rstn_o = rstn AND NOT(state==CLEAR), so it is 0 during reset.
- The FSM has six states: IDLE, CLEAR, WAIT_WORD, LOAD, SHIFT, CAPTURE. busy=1 in every state except IDLE.
- IDLE:
  - start with frame_len != 0: latch remaining=frame_len and go to CLEAR.
  - start with frame_len == 0: err=1 for one cycle, stay in IDLE.
- CLEAR: crc_rstn_o=0 for exactly one cycle, which clears the PISO and LFSR. Next state is WAIT_WORD.
- WAIT_WORD:
  - word_ready=1 (combinational from state).
  - On word_valid: crc_data <= word_data, go to LOAD.
  - word_valid gaps of any length are legal.
- LOAD:
  - crc_load=1 and crc_enable=1 for one cycle.
  - crc_data stays stable until the next word is accepted.
  - Clear the timeout counter, go to SHIFT.
- SHIFT:
  - crc_enable=1 and the timeout counter increments each cycle.
  - On crc_done_tick, decrement remaining. If the value before the decrement was 1, go to CAPTURE; otherwise go to WAIT_WORD.
  - If the counter reaches TIMEOUT with no tick: err=1, go to IDLE. crc_result is unchanged and no done is issued.
- CAPTURE:
  - crc_enable=0.
  - Exactly one cycle after the final tick: crc_result <= crc_lfsr, done=1, go to IDLE.
- crc_result holds its value until the next CAPTURE or reset.
- Ticks outside SHIFT are ignored.
- abort (any non-IDLE state): go to IDLE next cycle, drop crc_enable/crc_load/word_ready, no done, no err. Abort has priority over the tick and the timeout in the same cycle.
- start while busy is ignored (not queued).
- rstn low mid-frame: immediate return to reset state, and the CRC block is reset through crc_rstn_o.
- Minimum frame latency: start to done = 1 (CLEAR) + N*(1 WAIT + 1 LOAD + PISO shift time) + 1 (CAPTURE) cycles, for N words with zero-gap word_valid.

Decomposition:
- Shared package crc_pkg:
  - state encoding localparams (IDLE=0, CLEAR=1, WAIT_WORD=2, LOAD=3, SHIFT=4, CAPTURE=5).
  - DW/CW defaults and the TIMEOUT default.
- No sub-module needed; a single FSM plus counters. The bench instantiates crc_frame_ctrl together with the existing CRC block and a behavioural FCS golden model.

Test Plan:
- 1-word frame, frame_len=1, word 0xDEADBEEF, word_valid held high:
  - CLEAR pulse seen on crc_rstn_o;
  - one crc_load;
  - done exactly one cycle after the tick;
  - crc_result equals the golden-model CRC of 0xDEADBEEF.
- 3-word frame (0x00000001, 0x12345678, 0xFFFFFFFF) with 5-cycle word_valid gaps: exactly 3 loads, busy stays high throughout, crc_result equals the golden CRC of the concatenated 96 bits.
- start with frame_len=0: err high for one cycle, busy stays 0, crc_result unchanged.
- Timeout: force crc_done_tick low after LOAD. err pulses when the counter reaches 80 cycles in SHIFT, then the FSM is in IDLE with crc_result unchanged.
- abort asserted in SHIFT of word 2 of 3, then a new 1-word frame of 0x00000000: no done for the aborted frame; the new frame's crc_result equals the golden CRC of 0x00000000 from a cleared LFSR.
- rstn pulled low for 2 cycles mid-SHIFT, plus start asserted while busy in another frame:
  - reset returns all outputs to their reset values;
  - the start while busy is ignored and does not change remaining.
